// File: rtl/button_debouncer.sv
// N-button debouncer: shared sample-tick prescaler, per-button 2-flop synchroniser
// and a 4-state qualification FSM producing a clean level plus press/release/repeat pulses.
module button_debouncer #(
  parameter int N            = 4,
  parameter int TICK_DIV     = 50_000,
  parameter int STABLE_TICKS = 10,
  parameter int REPEAT_TICKS = 200,
  parameter int WIDTH        = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_raw,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] press_pulse,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] repeat_pulse
);

  localparam int SW = $clog2(STABLE_TICKS + 1);
  localparam int RW = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;

  localparam logic [WIDTH-1:0] TICK_LAST = WIDTH'(TICK_DIV - 1);
  localparam logic [SW-1:0]    STAB_LAST = SW'(STABLE_TICKS - 1);
  localparam logic [RW-1:0]    REP_LAST  = RW'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    HELD,
    RELEASE_CHK
  } state_t;

  logic [WIDTH-1:0] r_presc;
  logic             w_tick;
  logic [N-1:0]     r_sync1;
  logic [N-1:0]     r_sync2;

  assign w_tick = (r_presc == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_btn
    state_t        r_state;
    state_t        w_state_nx;
    logic [SW-1:0] r_stab;
    logic [SW-1:0] w_stab_nx;
    logic [RW-1:0] r_rep;
    logic [RW-1:0] w_rep_nx;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          r_repeat;
    logic          w_level_nx;
    logic          w_press_nx;
    logic          w_release_nx;
    logic          w_repeat_nx;
    logic          w_sync;

    assign w_sync = r_sync2[gi];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state   <= RELEASED;
        r_stab    <= '0;
        r_rep     <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_repeat  <= 1'b0;
      end else begin
        r_state   <= w_state_nx;
        r_stab    <= w_stab_nx;
        r_rep     <= w_rep_nx;
        r_level   <= w_level_nx;
        r_press   <= w_press_nx;
        r_release <= w_release_nx;
        r_repeat  <= w_repeat_nx;
      end
    end

    // A level change on sync takes priority over a coincident tick in every state.
    always_comb begin
      w_state_nx   = r_state;
      w_stab_nx    = r_stab;
      w_rep_nx     = r_rep;
      w_level_nx   = r_level;
      w_press_nx   = 1'b0;
      w_release_nx = 1'b0;
      w_repeat_nx  = 1'b0;
      case (r_state)
        RELEASED: begin
          if (w_sync) begin
            w_state_nx = PRESS_CHK;
            w_stab_nx  = '0;
          end
        end
        PRESS_CHK: begin
          if (!w_sync) begin
            w_state_nx = RELEASED;
          end else if (w_tick) begin
            if (r_stab == STAB_LAST) begin
              w_state_nx = HELD;
              w_press_nx = 1'b1;
              w_level_nx = 1'b1;
              w_rep_nx   = '0;
            end else begin
              w_stab_nx = r_stab + 1'b1;
            end
          end
        end
        HELD: begin
          if (!w_sync) begin
            w_state_nx = RELEASE_CHK;
            w_stab_nx  = '0;
          end else if (w_tick && (REPEAT_TICKS != 0)) begin
            if (r_rep == REP_LAST) begin
              w_repeat_nx = 1'b1;
              w_rep_nx    = '0;
            end else begin
              w_rep_nx = r_rep + 1'b1;
            end
          end
        end
        RELEASE_CHK: begin
          if (w_sync) begin
            w_state_nx = HELD;
          end else if (w_tick) begin
            if (r_stab == STAB_LAST) begin
              w_state_nx   = RELEASED;
              w_release_nx = 1'b1;
              w_level_nx   = 1'b0;
            end else begin
              w_stab_nx = r_stab + 1'b1;
            end
          end
        end
        default: w_state_nx = RELEASED;
      endcase
    end

    assign btn_level[gi]     = r_level;
    assign press_pulse[gi]   = r_press;
    assign release_pulse[gi] = r_release;
    assign repeat_pulse[gi]  = r_repeat;
  end

endmodule
